// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS-style main controller FSM with ALU decode
module mc_controller #(
  parameter bit BNE_EN  = 1'b1,
  parameter bit ADDI_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q;
  state_t     state_d;
  logic       pcwrite;
  logic [1:0] aluop;

  // State register; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and the illegal-opcode pulse raised while decoding.
  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_BNE: begin
            if (BNE_EN) state_d = S_BNE;
            else        illegal = 1'b1;
          end
          OP_ADDI: begin
            if (ADDI_EN) state_d = S_ADDIEX;
            else         illegal = 1'b1;
          end
          default:      illegal = 1'b1;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      // A disabled addi path must never reach its writeback state.
      S_ADDIEX:  state_d = ADDI_EN ? S_ADDIWB : S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore decode of datapath controls; pcen folds in the branch condition.
  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    aluop    = 2'b00;
    case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_ADDIWB:  regwrite = 1'b1;
      S_BEQ, S_BNE: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    pcen = pcwrite | ((state_q == S_BEQ) & zero) | ((state_q == S_BNE) & ~zero);
  end

  // ALU operation from aluop, with R-type instructions decoded from funct.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller, full and reduced opcode sets
module tb_mc_controller;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Instruction steps as named in the controller description.
  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
    P_EXEC, P_ALUWB, P_BEQ, P_ADDIEX, P_ADDIWB, P_JUMP, P_BNE
  } phase_t;

  logic        clk = 1'b0;
  logic        reset_a [2];
  logic [5:0]  op_a    [2];
  logic [5:0]  funct_a [2];
  logic        zero_a  [2];
  logic [15:0] act     [2];

  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  // Instance 0: full opcode set; instance 1: bne and addi disabled.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    mc_controller #(.BNE_EN(g == 0), .ADDI_EN(g == 0)) dut (
      .clk        (clk),
      .reset      (reset_a[g]),
      .op         (op_a[g]),
      .funct      (funct_a[g]),
      .zero       (zero_a[g]),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .pcen       (pcen),
      .alucontrol (alucontrol),
      .illegal    (illegal)
    );
    assign act[g] = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, pcsrc, pcen, alucontrol, illegal};
  end

  function automatic logic [2:0] rtype_alu(input logic [5:0] funct);
    case (funct)
      6'b100000: return 3'b010;   // add
      6'b100010: return 3'b110;   // sub
      6'b100100: return 3'b000;   // and
      6'b100101: return 3'b001;   // or
      6'b101010: return 3'b111;   // slt
      default:   return 3'b010;
    endcase
  endfunction

  // Expected control bundle for one step of an instruction.
  function automatic logic [15:0] exp_vec(input phase_t p, input logic [5:0] funct,
                                          input logic zero, input logic ill);
    logic iord = 1'b0, memwrite = 1'b0, irwrite = 1'b0, regdst = 1'b0;
    logic memtoreg = 1'b0, regwrite = 1'b0, alusrca = 1'b0, pcen = 1'b0;
    logic [1:0] alusrcb = 2'b00, pcsrc = 2'b00;
    logic [2:0] aluc = 3'b010;
    case (p)
      P_FETCH:  begin irwrite = 1'b1; alusrcb = 2'b01; pcen = 1'b1; end
      P_DECODE: alusrcb = 2'b11;
      P_MEMADR, P_ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
      P_MEMRD:  iord = 1'b1;
      P_MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
      P_MEMWB:  begin memtoreg = 1'b1; regwrite = 1'b1; end
      P_EXEC:   begin alusrca = 1'b1; aluc = rtype_alu(funct); end
      P_ALUWB:  begin regdst = 1'b1; regwrite = 1'b1; end
      P_ADDIWB: regwrite = 1'b1;
      P_BEQ:    begin alusrca = 1'b1; aluc = 3'b110; pcsrc = 2'b01; pcen = zero; end
      P_BNE:    begin alusrca = 1'b1; aluc = 3'b110; pcsrc = 2'b01; pcen = ~zero; end
      P_JUMP:   begin pcsrc = 2'b10; pcen = 1'b1; end
      default: ;
    endcase
    return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, pcsrc, pcen, aluc, ill};
  endfunction

  task automatic push_exp(input int k, input logic [15:0] v);
    if (k == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic check(input int k, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL dut%0d controls at %0t: got %h, expected %h", k, $time, got, want);
    end
  endtask

  // Monitor: every cycle a step was issued, compare the live controls.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); check(0, act[0], e); end
      if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); check(1, act[1], e); end
    end
  end

  task automatic do_reset(input int k);
    reset_a[k] = 1'b1;
    op_a[k]    = 6'd0;
    funct_a[k] = 6'd0;
    zero_a[k]  = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    push_exp(k, exp_vec(P_FETCH, 6'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    reset_a[k] = 1'b0;
  endtask

  // Issue one instruction from FETCH; optionally assert reset during step abort_at
  // and hold it for hold further cycles. Returns at the start of a FETCH cycle.
  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] funct,
                           input logic zero, input int abort_at, input int hold);
    phase_t ph [5];
    int     n;
    logic   en;
    logic   ill;
    for (int i = 0; i < 5; i++) ph[i] = P_FETCH;
    en    = (k == 0);
    ill   = 1'b0;
    ph[1] = P_DECODE;
    n     = 2;
    case (op)
      OP_LW:    begin ph[2] = P_MEMADR; ph[3] = P_MEMRD; ph[4] = P_MEMWB; n = 5; end
      OP_SW:    begin ph[2] = P_MEMADR; ph[3] = P_MEMWR; n = 4; end
      OP_RTYPE: begin ph[2] = P_EXEC; ph[3] = P_ALUWB; n = 4; end
      OP_BEQ:   begin ph[2] = P_BEQ; n = 3; end
      OP_J:     begin ph[2] = P_JUMP; n = 3; end
      OP_BNE:   if (en) begin ph[2] = P_BNE; n = 3; end else ill = 1'b1;
      OP_ADDI:  if (en) begin ph[2] = P_ADDIEX; ph[3] = P_ADDIWB; n = 4; end else ill = 1'b1;
      default:  ill = 1'b1;
    endcase
    op_a[k]    = op;
    funct_a[k] = funct;
    zero_a[k]  = zero;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) reset_a[k] = 1'b1;
      push_exp(k, exp_vec(ph[i], funct, zero, ill && (ph[i] == P_DECODE)));
      @(posedge clk); #1;
      if (i == abort_at) begin
        for (int h = 0; h < hold; h++) begin
          push_exp(k, exp_vec(P_FETCH, funct, zero, 1'b0));
          @(posedge clk); #1;
        end
        reset_a[k] = 1'b0;
        return;
      end
    end
  endtask

  task automatic run_thread(input int k);
    logic [5:0] ops [7];
    logic [5:0] functs [5];
    logic [31:0] r;
    logic [5:0] op;
    logic [5:0] fn;
    int abort_at;
    int hold;
    ops    = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    do_reset(k);
    run_instr(k, OP_LW,     6'd0,      1'b0, -1, 0);
    run_instr(k, OP_SW,     6'd0,      1'b0, -1, 0);
    run_instr(k, OP_RTYPE,  6'b101010, 1'b0, -1, 0);
    run_instr(k, OP_RTYPE,  6'b111111, 1'b0, -1, 0);
    run_instr(k, OP_BEQ,    6'd0,      1'b1, -1, 0);
    run_instr(k, OP_BEQ,    6'd0,      1'b0, -1, 0);
    run_instr(k, OP_BNE,    6'd0,      1'b1, -1, 0);
    run_instr(k, OP_BNE,    6'd0,      1'b0, -1, 0);
    run_instr(k, OP_J,      6'd0,      1'b0, -1, 0);
    run_instr(k, 6'b111111, 6'd0,      1'b0, -1, 0);
    run_instr(k, OP_ADDI,   6'd0,      1'b0, -1, 0);
    run_instr(k, OP_SW,     6'd0,      1'b0,  3, 2);
    run_instr(k, OP_LW,     6'd0,      1'b1,  2, 0);
    run_instr(k, OP_LW,     6'd0,      1'b0, -1, 0);
    repeat (200) begin
      r = $urandom();
      if (r[3:0] < 4'd12) op = ops[r[3:0] % 7];
      else                op = r[9:4];
      r = $urandom();
      if (r[2:0] < 3'd5) fn = functs[r[2:0]];
      else               fn = r[8:3];
      abort_at = -1;
      hold     = 0;
      if ($urandom_range(0, 9) == 0) begin
        abort_at = $urandom_range(0, 4);
        hold     = $urandom_range(0, 3);
      end
      run_instr(k, op, fn, 1'($urandom_range(0, 1)), abort_at, hold);
    end
  endtask

  initial begin
    fork
      run_thread(0);
      run_thread(1);
    join
    @(posedge clk); #1;
    n_checks++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0",
               exp_q0.size() + exp_q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL expose parameter BNE_EN, default 1, which enables the bne opcode (000101); 0 treats bne as illegal.
REQ-002 The block SHALL expose parameter ADDI_EN, default 1, which enables the addi opcode (001000); 0 treats addi as illegal.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports op and funct, input, 6 bits each: instruction opcode and R-type function field.
REQ-006 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 The block SHALL have ports iord, memwrite, irwrite, regdst, memtoreg, regwrite and alusrca, output, 1 bit each: datapath selects and enables.
REQ-008 The block SHALL have ports alusrcb and pcsrc, output, 2 bits each: ALU B-operand mux select and next-PC mux select.
REQ-009 The block SHALL have port pcen, output, 1 bit: PC register write enable.
REQ-010 The block SHALL have port alucontrol, output, 3 bits: ALU operation.
REQ-011 The block SHALL have port illegal, output, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-012 The block SHALL use a 4-bit state register with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12.
REQ-013 Transitions SHALL be as follows:
- FETCH->DECODE
- DECODE on op: lw(100011)/sw(101011)->MEMADR; R-type(000000)->EXECUTE; beq(000100)->BEQ; bne->BNE; addi->ADDIEX; j(000010)->JUMP; any other->FETCH
- MEMADR->MEMRD if lw, else MEMWR
- MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB
- MEMWB, MEMWR, ALUWB, ADDIWB, BEQ, BNE, JUMP->FETCH
- codes 13-15->FETCH
REQ-014 Outputs SHALL be Moore decodes of state, except pcen. Any signal not listed for a state SHALL be 0; alusrcb and pcsrc default to 00.
- FETCH: irwrite=1, alusrcb=01, pcsrc=00, pcwrite=1, aluop=00
- DECODE: alusrcb=11, aluop=00
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00
- MEMRD: iord=1
- MEMWR: iord=1, memwrite=1
- MEMWB: memtoreg=1, regwrite=1
- EXECUTE: alusrca=1, aluop=10
- ALUWB: regdst=1, regwrite=1
- ADDIWB: regwrite=1
- BEQ and BNE: alusrca=1, aluop=01, pcsrc=01
- JUMP: pcsrc=10, pcwrite=1
REQ-015 pcen SHALL be computed combinationally as pcwrite | (state==BEQ & zero) | (state==BNE & ~zero).
REQ-016 alucontrol SHALL decode as follows:
- aluop=00 -> 010; aluop=01 -> 110
- aluop=10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010
REQ-017 illegal SHALL be 1 only in the DECODE cycle whose op is unsupported under the current parameters; the next state is then FETCH.
REQ-018 With BNE_EN=0 or ADDI_EN=0, states BNE/ADDIEX/ADDIWB SHALL be unreachable, and any entry into them SHALL exit to FETCH on the next cycle.
REQ-019 Instruction latency SHALL be: lw 5 cycles; sw, R-type and addi 4; beq, bne and j 3.

Reset
REQ-020 reset=1 at a rising edge SHALL force state to FETCH regardless of current state, including mid-instruction.
REQ-021 While reset=1, outputs SHALL reflect FETCH from the cycle after the edge: irwrite=1, pcen=1, alusrcb=01, alucontrol=010, illegal=0, all others 0.
REQ-022 reset SHALL take priority over every transition; no memwrite or regwrite SHALL assert in the cycle following a reset edge.

Verification
REQ-023 lw (op=100011) after reset -> states 0,1,2,3,4,0; memtoreg=regwrite=1 only in cycle 5; iord=1 in cycle 4.
REQ-024 R-type, op=000000, funct=101010 -> EXECUTE shows alucontrol=111 and alusrca=1; ALUWB shows regdst=regwrite=1; return to FETCH after 4 cycles.
REQ-025 beq with zero=1 -> pcen=1 and pcsrc=01 in the BEQ cycle; bne with zero=1 -> pcen=0; bne with zero=0 -> pcen=1.
REQ-026 op=111111 -> illegal=1 for exactly one DECODE cycle, then FETCH; with BNE_EN=0, op=000101 also gives illegal=1.
REQ-027 reset asserted during MEMWR -> the next cycle is FETCH with memwrite=0; reset held 3 cycles -> state stays FETCH.
REQ-028 j (op=000010) -> JUMP cycle with pcsrc=10 and pcen=1, then FETCH; total 3 cycles.
